// File: rtl/video_sprite_loader.sv
// Purpose : Avalon-MM write initiator that loads a sprite bitmap from a sync ROM into the
//           sprite core (bypass on, pixels, x/y origin, bypass off), or rewrites only the origin.
// Latency : start -> first write next cycle, done 2*NPIX+5 cycles after start; pos_upd -> done in 3.
// Backpr. : avm_waitrequest_i stalls the FSM; address/data/write are held until the write completes.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start_i             pulse, full load (accepted only when idle)
//   pos_upd_i           pulse, origin-only update (accepted only when idle; start wins)
//   x_pos_i, y_pos_i    origin, captured when a pulse is accepted
//   busy_o              sequence in progress
//   done_o              one-cycle pulse in the first idle cycle after a sequence
//   rom_addr_o          sprite ROM read address
//   rom_data_i          sprite ROM data, one cycle after rom_addr_o
//   avm_write_o, avm_address_o, avm_writedata_o, avm_waitrequest_i   Avalon-MM write master

module video_sprite_loader #(
   parameter int RGB_SIZE      = 12,
   parameter int SPRITE_HSIZE  = 32,
   parameter int SPRITE_VSIZE  = 32,
   parameter int SPRITE_RAM_AW = 10,
   parameter int ADDR_W        = SPRITE_RAM_AW + 2,
   parameter int PIX_BASE      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic                     pos_upd_i,
   input  logic [31:0]              x_pos_i,
   input  logic [31:0]              y_pos_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [SPRITE_RAM_AW-1:0] rom_addr_o,
   input  logic [RGB_SIZE-1:0]      rom_data_i,
   output logic                     avm_write_o,
   output logic [ADDR_W-1:0]        avm_address_o,
   output logic [31:0]              avm_writedata_o,
   input  logic                     avm_waitrequest_i
);

   localparam int NPIX   = SPRITE_HSIZE * SPRITE_VSIZE;
   localparam int LAST_I = NPIX - 1;
   localparam logic [SPRITE_RAM_AW:0] LAST_PIX = LAST_I[SPRITE_RAM_AW:0];

   typedef enum logic [2:0] {
      S_IDLE,
      S_BYP_ON,
      S_PIX_RD,
      S_PIX_WR,
      S_XO_WR,
      S_YO_WR,
      S_BYP_OFF
   } state_t;

   state_t                   state_q, state_d;
   logic [SPRITE_RAM_AW:0]   pix_cnt_q, pix_cnt_d;
   logic [31:0]              x_q, x_d;
   logic [31:0]              y_q, y_d;
   logic                     full_q, full_d;      // 1: full load, 0: origin-only update
   logic                     done_q, done_d;
   logic [RGB_SIZE-1:0]      pix_dat_q, pix_dat_d;
   logic                     pix_new_q, pix_new_d; // first cycle of PIX_WR: ROM output is fresh

   logic                     wr_ok;
   logic [RGB_SIZE-1:0]      pix_sel;
   logic [ADDR_W-1:0]        pix_addr;

   assign wr_ok    = ~avm_waitrequest_i;
   // Take the ROM word on entry to PIX_WR, then replay the captured copy through stalls.
   assign pix_sel  = pix_new_q ? rom_data_i : pix_dat_q;
   assign pix_addr = ADDR_W'(PIX_BASE) + ADDR_W'({pix_cnt_q, 1'b0});

   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = done_q;
   assign rom_addr_o = pix_cnt_q[SPRITE_RAM_AW-1:0];

   always_comb begin
      state_d         = state_q;
      pix_cnt_d       = pix_cnt_q;
      x_d             = x_q;
      y_d             = y_q;
      full_d          = full_q;
      done_d          = 1'b0;
      pix_dat_d       = pix_dat_q;
      pix_new_d       = 1'b0;
      avm_write_o     = 1'b0;
      avm_address_o   = '0;
      avm_writedata_o = '0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_BYP_ON;
               pix_cnt_d = '0;
               x_d       = x_pos_i;
               y_d       = y_pos_i;
               full_d    = 1'b1;
            end else if (pos_upd_i) begin
               state_d = S_XO_WR;
               x_d     = x_pos_i;
               y_d     = y_pos_i;
               full_d  = 1'b0;
            end
         end
         S_BYP_ON: begin
            avm_write_o     = 1'b1;
            avm_writedata_o = 32'd1;
            if (wr_ok) state_d = S_PIX_RD;
         end
         S_PIX_RD: begin
            state_d   = S_PIX_WR;
            pix_new_d = 1'b1;
         end
         S_PIX_WR: begin
            avm_write_o     = 1'b1;
            avm_address_o   = pix_addr;
            avm_writedata_o = {{(32-RGB_SIZE){1'b0}}, pix_sel};
            pix_dat_d       = pix_sel;
            if (wr_ok) begin
               if (pix_cnt_q == LAST_PIX) begin
                  state_d = S_XO_WR;
               end else begin
                  pix_cnt_d = pix_cnt_q + 1'b1;
                  state_d   = S_PIX_RD;
               end
            end
         end
         S_XO_WR: begin
            avm_write_o     = 1'b1;
            avm_address_o   = ADDR_W'(4);
            avm_writedata_o = x_q;
            if (wr_ok) state_d = S_YO_WR;
         end
         S_YO_WR: begin
            avm_write_o     = 1'b1;
            avm_address_o   = ADDR_W'(8);
            avm_writedata_o = y_q;
            if (wr_ok) begin
               if (full_q) begin
                  state_d = S_BYP_OFF;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         S_BYP_OFF: begin
            avm_write_o = 1'b1;
            if (wr_ok) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pix_cnt_q <= '0;
         x_q       <= '0;
         y_q       <= '0;
         full_q    <= 1'b0;
         done_q    <= 1'b0;
         pix_dat_q <= '0;
         pix_new_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
         x_q       <= x_d;
         y_q       <= y_d;
         full_q    <= full_d;
         done_q    <= done_d;
         pix_dat_q <= pix_dat_d;
         pix_new_q <= pix_new_d;
      end
   end

endmodule
